muldiv_unit: RTL



---
 rtl/muldiv_unit_pkg.sv | 34 +++
 rtl/muldiv_unit_arith.sv | 54 +++++
 rtl/muldiv_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the default busy lengths for multiply and divide.
package md_defs;

    // Operation select driven by the decoder alongside start/we_hilo.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NONE  = 3'd7
    } md_op_e;

    // Unit sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Counter is wide enough for any reasonable cycle count.
    localparam int CNT_W = 8;

    // Signed flavour of an arithmetic op (MULT or DIV).
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_arith.sv
// Purely combinational arithmetic core: full 64-bit product and the
// quotient/remainder pair, in signed or unsigned form chosen by the op code.
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_product,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_zero
);

    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    assign w_signed = md_is_signed(i_op);

    // Extend both operands to 64 bits; the low 64 bits of the unsigned
    // product of sign-extended operands equal the signed product.
    always_comb begin
        w_a_ext   = w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
        w_b_ext   = w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
        o_product = w_a_ext * w_b_ext;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000 has magnitude
    // 0x80000000 as an unsigned value, so the overflow case falls out
    // naturally as 0x80000000 / 1 negated back to 0x80000000.
    always_comb begin
        w_a_neg    = w_signed & i_a[31];
        w_b_neg    = w_signed & i_b[31];
        w_a_mag    = w_a_neg ? (~i_a + 32'd1) : i_a;
        w_b_mag    = w_b_neg ? (~i_b + 32'd1) : i_b;
        o_div_zero = (i_b == 32'd0);
        // Keep the divider away from zero; the result is discarded anyway.
        w_b_safe   = o_div_zero ? 32'd1 : w_b_mag;
        w_q_mag    = w_a_mag / w_b_safe;
        w_r_mag    = w_a_mag % w_b_safe;
        o_quotient  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        o_remainder = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit. Owns HI/LO, computes the result at the
// start edge into shadow registers, then holds busy for a fixed number of
// cycles before committing, mimicking a multi-cycle functional unit.
//
// Handshake: start/we_hilo are only honoured while idle (busy=0); the hazard
// unit stalls on md_stall so nothing is presented while busy. Anything that
// does arrive while busy is dropped without effect.
module muldiv_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we_hilo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_shadow_hi;
    logic [31:0]      r_shadow_lo;
    logic             r_commit;
    logic             r_busy;

    logic [63:0]      w_product;
    logic [31:0]      w_quotient;
    logic [31:0]      w_remainder;
    logic             w_div_zero;
    logic             w_is_mult;
    logic             w_is_div;

    md_arith u_arith (
        .i_op        (md_op),
        .i_a         (rs_val),
        .i_b         (rt_val),
        .o_product   (w_product),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder),
        .o_div_zero  (w_div_zero)
    );

    assign w_is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign w_is_div  = (md_op == MD_DIV)  || (md_op == MD_DIVU);

    // Sequencer: launch from idle, count down, commit shadow into HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_shadow_hi <= '0;
            r_shadow_lo <= '0;
            r_commit    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // start outranks we_hilo; unknown ops are dropped.
                        if (w_is_mult) begin
                            r_shadow_hi <= w_product[63:32];
                            r_shadow_lo <= w_product[31:0];
                            r_commit    <= 1'b1;
                            r_cnt       <= CNT_W'(MULT_CYCLES - 1);
                            r_busy      <= 1'b1;
                            r_state     <= ST_MULT;
                        end else if (w_is_div) begin
                            r_shadow_hi <= w_remainder;
                            r_shadow_lo <= w_quotient;
                            // Divide by zero still burns the full latency
                            // but leaves HI/LO untouched.
                            r_commit    <= ~w_div_zero;
                            r_cnt       <= CNT_W'(DIV_CYCLES - 1);
                            r_busy      <= 1'b1;
                            r_state     <= ST_DIV;
                        end
                    end else if (we_hilo) begin
                        if (md_op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    if (r_cnt == '0) begin
                        if (r_commit) begin
                            r_hi <= r_shadow_hi;
                            r_lo <= r_shadow_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign md_stall = r_busy | start;

endmodule
